mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the core's single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads and stores). It latches one request at a time, drives the shared memory with registered signals, and waits for `mem_ack`. It then returns a one-cycle ready to the winner; the pipeline uses the ready signals as stall/enable conditions. Data requests have priority, bounded by a fetch anti-starvation counter, and in-flight fetches can be killed on a taken branch or jump.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits before fetch is forced.
- `TIMEOUT_CYCLES`, 64: busy cycles without `mem_ack` before abort (only with `MEM_ARB_TIMEOUT_EN`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_ready` or `if_flush`.
- `if_addr` in 32: fetch word address.
- `if_flush` in 1: discard the pending or in-flight fetch (driven by PCSrcE).
- `if_ready` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: instruction word.
- `dm_req` in 1: data request; held until `dm_ready`.
- `dm_we` in 1: 1 = store.
- `dm_be` in 4: byte enables.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: store data.
- `dm_ready` out 1: one-cycle pulse; `dm_rdata` valid for loads.
- `dm_rdata` out 32: load data.
- `mem_req` out 1: registered; high for the whole transaction.
- `mem_we` out 1: registered.
- `mem_be` out 4: registered.
- `mem_addr` out 32: registered.
- `mem_wdata` out 32: registered.
- `mem_rdata` in 32: valid when `mem_ack` = 1.
- `mem_ack` in 1: one-cycle completion from memory.
- `err` out 1: sticky timeout flag; tied 0 without the macro.

## Operation
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE, arbitration:
  - Fetch wins if `if_req && !if_flush` and the starve counter equals `STARVE_LIMIT`.
  - Otherwise `dm_req` wins.
  - Otherwise `if_req && !if_flush` wins.
  - The winner's address, we, be and wdata are latched into the `mem_*` registers; `mem_req` is set and the FSM enters the matching BUSY state.
  - Fetch requests always latch `mem_we` = 0 and `mem_be` = 4'hF.
- Starve counter:
  - Increments on each DM grant while `if_req` is high.
  - Clears on any IF grant, or when `if_req` is low in IDLE.
  - Saturates at `STARVE_LIMIT`.
- BUSY with `mem_ack` = 1:
  - Pulse the winner's ready; `x_rdata` = `mem_rdata` combinationally.
  - Clear `mem_req` and return to IDLE. At least one IDLE cycle separates transactions.
- Flush:
  - `if_flush` in IF_BUSY, on any cycle up to and including the ack cycle, sets a drop flag.
  - On ack with the drop flag set, `if_ready` stays 0. The drop flag clears on leaving IF_BUSY.
  - `if_flush` has no effect on DM transactions.
- Stray `mem_ack` in IDLE is ignored.
- Outputs `if_rdata` and `dm_rdata` read 0 when not ready.
- Memory-side `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are 0 in IDLE.

## Timing
- Reset (`rst` = 0, async): state IDLE.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` = 0.
  - Ready outputs = 0, `err` = 0.
  - Starve counter, drop flag and timeout counter = 0.
- A reset mid-transaction abandons it; the memory sees `mem_req` fall asynchronously.
- A request sampled at edge N drives `mem_req` = 1 from cycle N+1.
- Ready is asserted in the same cycle as `mem_ack`.
- Minimum round trip: request seen at cycle 0, ack at cycle 1, ready at cycle 1.
- Back-to-back: the next grant is sampled in the IDLE cycle after ready, so the new `mem_req` appears 2 cycles after the previous ready.
- Simultaneous `if_req` and `dm_req` in IDLE resolve by the priority rule above, in one cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs in the BUSY states and resets on entry.
  - Reaching `TIMEOUT_CYCLES` without ack does the following:
    - pulses the winner's ready (unless a fetch is being dropped) with rdata = 32'h0;
    - sets `err` (sticky until reset);
    - clears `mem_req` and returns to IDLE.
- Not defined: BUSY waits indefinitely for `mem_ack`; `err` is tied 0.

## Test plan
- Fetch only: `if_addr` = 0x0000_0010, memory acks 3 cycles after `mem_req` with 0x0050_0093.
  - Expect `mem_we` = 0 and `mem_be` = 4'hF.
  - Expect an `if_ready` pulse with `if_rdata` = 0x0050_0093 in the ack cycle.
- Simultaneous `if_req` and store (`dm_addr` = 0x100, `dm_wdata` = 0xDEADBEEF, `dm_be` = 4'b0011).
  - Expect the DM grant first with `mem_we` = 1 and `mem_be` = 4'b0011.
  - Expect the IF grant in the next arbitration.
- Starvation: `if_req` held while 6 back-to-back `dm_req` are issued, `STARVE_LIMIT` = 4.
  - Expect the 5th grant to be IF and the remaining DM requests served afterwards.
- Flush: `if_flush` pulsed 1 cycle after an IF grant.
  - Expect `mem_req` to remain high until ack, `if_ready` to stay 0 at ack, then IDLE.
- Reset mid DM transaction: drive `rst` low in DM_BUSY.
  - Expect `mem_req`, `dm_ready` and all `mem_*` outputs to be 0 immediately.
  - Expect a later `mem_ack` to be ignored.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: issue `dm_req` and withhold ack.
  - Expect `dm_ready` with `dm_rdata` = 0 after 8 busy cycles.
  - Expect `err` = 1 to stay set and `mem_req` to drop.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single unified memory port.
// Define MEM_ARB_TIMEOUT_EN for the busy timeout with a sticky err flag.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 2) begin : gBadCfg
    $error("mem_port_arbiter: STARVE_LIMIT or TIMEOUT_CYCLES out of range");
  end

  state_t        state;
  logic [SW-1:0] starveCnt;
  logic          dropFlag;
  logic          ifLive;
  logic          forceIf;
  logic          grantDm;
  logic          grantIf;
  logic          busy;
  logic          timeoutHit;
  logic          done;
  logic          ifDrop;

  assign ifLive  = if_req && !if_flush;
  assign forceIf = ifLive && (starveCnt == SW'(STARVE_LIMIT));
  assign grantDm = dm_req && !forceIf;
  assign grantIf = ifLive && !grantDm;
  assign busy    = state != IDLE;
  assign done    = busy && (mem_ack || timeoutHit);
  assign ifDrop  = dropFlag || if_flush;

  assign if_ready = (state == IF_BUSY) && done && !ifDrop;
  assign dm_ready = (state == DM_BUSY) && done;
  assign if_rdata = (if_ready && mem_ack) ? mem_rdata : '0;
  assign dm_rdata = (dm_ready && mem_ack) ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] toCnt;
  logic          errQ;

  // Fires on the last allowed busy cycle so ready lands there.
  assign timeoutHit = busy && !mem_ack &&
                      (toCnt == TW'(TIMEOUT_CYCLES - 1));
  assign err = errQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      if (!busy) toCnt <= '0;
      else toCnt <= toCnt + TW'(1);
      if (timeoutHit) errQ <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      dropFlag  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          dropFlag <= 1'b0;
          if (grantDm) begin
            state     <= DM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req) starveCnt <= '0;
            else if (starveCnt != SW'(STARVE_LIMIT))
              starveCnt <= starveCnt + SW'(1);
          end else if (grantIf) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            starveCnt <= '0;
          end else if (!if_req) begin
            starveCnt <= '0;
          end
        end
        IF_BUSY, DM_BUSY: begin
          if (state == IF_BUSY && if_flush) dropFlag <= 1'b1;
          if (done) begin
            state     <= IDLE;
            dropFlag  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grant and ready queues.
// Runs the timeout scenario when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isDm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } grant_t;

  typedef struct {
    bit          isDm;
    logic [31:0] rdata;
    bit          chkData;
    bit          ack;
  } rdy_t;

  grant_t gq[$];
  rdy_t   rq[$];
  grant_t mg;
  rdy_t   mr;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic failNow(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout want completion", name);
  endtask

  task automatic expGrant(bit isDm, logic we, logic [3:0] be,
                          logic [31:0] a, logic [31:0] wd, int gap);
    gq.push_back('{isDm, we, be, a, wd, gap});
  endtask

  task automatic expReady(bit isDm, logic [31:0] d, bit cd, bit ack);
    rq.push_back('{isDm, d, cd, ack});
  endtask

  function automatic logic [31:0] respFor(logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], 16'hC0DE};
  endfunction

  // memory responder
  int ackDelay   = 1;
  bit respEnable = 1'b1;
  bit strayAck   = 1'b0;
  int waitCnt    = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (strayAck) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
      end else if (respEnable && mem_req) begin
        if (waitCnt >= ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = respFor(mem_addr);
          waitCnt   = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // monitor
  int   cyc     = 0;
  int   lastRdy = -100;
  logic prevReq = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prevReq) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant: got addr %h want no grant", mem_addr);
        end else begin
          mg = gq.pop_front();
          chk("grantWe", 32'(mem_we), 32'(mg.we));
          chk("grantBe", 32'(mem_be), 32'(mg.be));
          chk("grantAddr", mem_addr, mg.addr);
          if (mg.isDm) chk("grantWdata", mem_wdata, mg.wdata);
          if (mg.gap >= 0) chk("grantGap", cyc - lastRdy, mg.gap);
        end
      end
      if (!mem_req && prevReq)
        chk("idleBus", mem_addr | mem_wdata |
            {27'b0, mem_we, mem_be}, 32'h0);
      prevReq = mem_req;
      if (if_ready || dm_ready) begin
        lastRdy = cyc;
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready: got if=%0b dm=%0b want none",
                   if_ready, dm_ready);
        end else begin
          mr = rq.pop_front();
          chk("readyPort", 32'({if_ready, dm_ready}),
              mr.isDm ? 32'h1 : 32'h2);
          if (mr.chkData)
            chk("rdata", mr.isDm ? dm_rdata : if_rdata, mr.rdata);
          chk("readyAck", 32'(mem_ack), 32'(mr.ack));
        end
      end
    end
  end

  task automatic ifRequest(input logic [31:0] a, output bit ok);
    ok      = 1'b0;
    if_req  = 1'b1;
    if_addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if_req  = 1'b0;
    if_addr = '0;
  endtask

  task automatic dmRequest(input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd,
                           output bit ok);
    ok       = 1'b0;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_be    = be;
    dm_addr  = a;
    dm_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dm_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_be    = '0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  task automatic waitReq(string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) return;
    end
    failNow(name);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  bit          okIf, okDm;
  logic [31:0] a;
  int          n;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0;
    dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rstMemReq", 32'(mem_req), 32'h0);
    chk("rstReady", 32'({if_ready, dm_ready}), 32'h0);
    chk("rstErr", 32'(err), 32'h0);
    chk("rstBus", mem_addr | mem_wdata | {27'b0, mem_we, mem_be}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    settle();

    // fetch only
    ackDelay = 3;
    expGrant(0, 1'b0, 4'hF, 32'h10, '0, -1);
    expReady(0, 32'h0050_0093, 1, 1);
    ifRequest(32'h10, okIf);
    if (!okIf) failNow("fetchOnly");
    settle();

    // simultaneous fetch and store
    ackDelay = 1;
    expGrant(1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, -1);
    expGrant(0, 1'b0, 4'hF, 32'h20, '0, 2);
    expReady(1, '0, 0, 1);
    expReady(0, 32'h0020_C0DE, 1, 1);
    fork
      begin
        ifRequest(32'h20, okIf);
        if (!okIf) failNow("simIf");
      end
      begin
        dmRequest(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, okDm);
        if (!okDm) failNow("simDm");
      end
    join
    settle();

    // starvation: IF forced on the 5th grant
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        expGrant(0, 1'b0, 4'hF, 32'h40, '0, 2);
        expReady(0, 32'h0040_C0DE, 1, 1);
      end
      a = 32'h1000 + 32'(k * 4);
      expGrant(1, 1'b0, 4'hF, a, '0, (k == 0) ? -1 : 2);
      expReady(1, {a[15:0], 16'hC0DE}, 1, 1);
    end
    fork
      begin
        ifRequest(32'h40, okIf);
        if (!okIf) failNow("starveIf");
      end
      begin
        for (int k = 0; k < 6; k++) begin
          dmRequest(1'b0, 4'hF, 32'h1000 + 32'(k * 4), '0, okDm);
          if (!okDm) failNow("starveDm");
        end
      end
    join
    settle();

    // flush one cycle after the IF grant
    ackDelay = 3;
    expGrant(0, 1'b0, 4'hF, 32'h80, '0, -1);
    if_req  = 1'b1;
    if_addr = 32'h80;
    waitReq("flushGrant");
    @(posedge clk);
    #1;
    if_flush = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    @(posedge clk);
    #1;
    if_flush = 1'b0;
    @(negedge clk);
    chk("flushReqHeld", 32'(mem_req), 32'h1);
    n = 0;
    while (!mem_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ack) failNow("flushAck");
    chk("flushNoReady", 32'(if_ready), 32'h0);
    @(negedge clk);
    chk("flushIdle", 32'(mem_req), 32'h0);
    settle();

    // reset in the middle of a DM transaction
    ackDelay = 3;
    expGrant(1, 1'b0, 4'hF, 32'h200, '0, -1);
    dm_req  = 1'b1;
    dm_be   = 4'hF;
    dm_addr = 32'h200;
    waitReq("rstGrant");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstMidReq", 32'(mem_req), 32'h0);
    chk("rstMidReady", 32'(dm_ready), 32'h0);
    chk("rstMidBus", mem_addr | mem_wdata | {27'b0, mem_we, mem_be}, 32'h0);
    dm_req  = 1'b0;
    dm_be   = '0;
    dm_addr = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    strayAck = 1'b1;
    @(negedge clk);
    chk("strayReady", 32'({if_ready, dm_ready}), 32'h0);
    @(posedge clk);
    #1;
    strayAck = 1'b0;
    @(negedge clk);
    chk("strayIdle", 32'(mem_req), 32'h0);
    settle();

    // normal load after reset
    ackDelay = 1;
    expGrant(1, 1'b0, 4'hF, 32'h200, '0, -1);
    expReady(1, 32'h0200_C0DE, 1, 1);
    dmRequest(1'b0, 4'hF, 32'h200, '0, okDm);
    if (!okDm) failNow("postRstLoad");
    settle();

`ifdef MEM_ARB_TIMEOUT_EN
    respEnable = 1'b0;
    expGrant(1, 1'b0, 4'hF, 32'h300, '0, -1);
    expReady(1, 32'h0, 1, 0);
    dm_req  = 1'b1;
    dm_be   = 4'hF;
    dm_addr = 32'h300;
    waitReq("toGrant");
    n = 0;
    while (!dm_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("toLatency", n, 7);
    @(posedge clk);
    #1;
    dm_req  = 1'b0;
    dm_be   = '0;
    dm_addr = '0;
    @(negedge clk);
    chk("toErr", 32'(err), 32'h1);
    chk("toReqDrop", 32'(mem_req), 32'h0);
    repeat (3) @(negedge clk);
    chk("toErrSticky", 32'(err), 32'h1);
    respEnable = 1'b1;
`else
    chk("errTied", 32'(err), 32'h0);
`endif

    for (int i = 0; i < 50; i++) begin
      if (gq.size() == 0 && rq.size() == 0) break;
      @(negedge clk);
    end
    chk("grantsLeft", gq.size(), 0);
    chk("readiesLeft", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
